multicycle_control: RTL and testbench

Parametrised multi-cycle successor to the single-cycle `Control_Logic` decoder. It latches one LEGv8 instruction per fetch and sequences it through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states. It drives the same datapath control lines as the single-cycle block, plus PC/IR write enables and memory handshakes. It sits between instruction memory, data memory and the shared datapath (register file, ALU, PC).

---
 rtl/multicycle_control_if.sv | 38 +++
 rtl/multicycle_control.sv | 158 +++++++++++++++
 tb/tb_multicycle_control.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Bus between the multi-cycle LEGv8 control unit and its environment:
// the instruction/memory handshakes in, the datapath control lines out.
interface multicycle_control_if #(
    parameter int INSTR_W = 32,
    parameter int ALUOP_W = 4
);
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic               mem_ready;

    logic               Reg2Loc;
    logic               UncondBranch;
    logic               Branch;
    logic               MemRead;
    logic               MemReg;
    logic               MemWrite;
    logic               ALUscr;
    logic               RegWrite;
    logic [ALUOP_W-1:0] ALUop;
    logic               PCWrite;
    logic               IRWrite;
    logic               busy;
    logic               fault;

    // Environment side: memories and datapath.
    modport master (
        output instruction, instr_valid, mem_ready,
        input  Reg2Loc, UncondBranch, Branch, MemRead, MemReg, MemWrite,
               ALUscr, RegWrite, ALUop, PCWrite, IRWrite, busy, fault
    );

    // Control unit side.
    modport slave (
        input  instruction, instr_valid, mem_ready,
        output Reg2Loc, UncondBranch, Branch, MemRead, MemReg, MemWrite,
               ALUscr, RegWrite, ALUop, PCWrite, IRWrite, busy, fault
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control unit: latches one instruction per fetch and walks it
// through FETCH/DECODE/EXEC/MEM/WB, driving Moore datapath controls from state+IR.
module multicycle_control #(
    parameter int INSTR_W  = 32,
    parameter int ALUOP_W  = 4,
    parameter int MAX_WAIT = 15
) (
    input logic                 clk,
    input logic                 rst,
    multicycle_control_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    state_t             state, state_nxt;
    logic [INSTR_W-1:0] ir;
    logic [CNT_W-1:0]   wait_cnt;
    logic [10:0]        opc;
    logic               ir_unused;

    logic is_ldur, is_stur, is_add, is_sub, is_and, is_orr, is_cbz, is_b;
    logic is_rtype, is_mem, legal;
    logic [ALUOP_W-1:0] alu_code;

    logic               reg2loc, uncond, branch, mem_read, mem_reg, mem_write;
    logic               alu_src, reg_write, pc_write, ir_write, busy, fault;
    logic [ALUOP_W-1:0] alu_op;

    assign opc       = ir[INSTR_W-1 -: 11];
    assign ir_unused = ^ir[INSTR_W-12:0];

    // Opcode decode from the latched IR.
    always_comb begin
        is_ldur  = (opc == 11'b11111000010);
        is_stur  = (opc == 11'b11111000000);
        is_add   = (opc == 11'b10001011000);
        is_sub   = (opc == 11'b11001011000);
        is_and   = (opc == 11'b10001010000);
        is_orr   = (opc == 11'b10101010000);
        is_cbz   = (opc[10:3] == 8'b10110100);
        is_b     = (opc[10:5] == 6'b000101);
        is_rtype = is_add | is_sub | is_and | is_orr;
        is_mem   = is_ldur | is_stur;
        legal    = is_rtype | is_mem | is_cbz | is_b;
    end

    always_comb begin
        alu_code = '0;
        if (is_add || is_ldur || is_stur) alu_code = ALUOP_W'(4'b0010);
        else if (is_sub)                  alu_code = ALUOP_W'(4'b0110);
        else if (is_orr)                  alu_code = ALUOP_W'(4'b0001);
        else if (is_cbz)                  alu_code = ALUOP_W'(4'b0111);
    end

    // IR and wait counter; the counter is cleared on the way into MEM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir       <= '0;
            wait_cnt <= '0;
        end else begin
            if (state == FETCH && bus.instr_valid)
                ir <= bus.instruction;
            if (state == EXEC)
                wait_cnt <= '0;
            else if (state == MEM && !bus.mem_ready && wait_cnt != CNT_W'(MAX_WAIT))
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:  if (bus.instr_valid) state_nxt = DECODE;
            DECODE: state_nxt = legal ? EXEC : TRAP;
            EXEC: begin
                if (is_cbz || is_b) state_nxt = FETCH;
                else if (is_mem)    state_nxt = MEM;
                else                state_nxt = WB;
            end
            // Completion is checked before the timeout so a late ready still wins.
            MEM: begin
                if (bus.mem_ready)                       state_nxt = is_ldur ? WB : FETCH;
                else if (wait_cnt == CNT_W'(MAX_WAIT))   state_nxt = TRAP;
            end
            WB:     state_nxt = FETCH;
            TRAP:   state_nxt = TRAP;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        reg2loc   = 1'b0;
        uncond    = 1'b0;
        branch    = 1'b0;
        mem_read  = 1'b0;
        mem_reg   = 1'b0;
        mem_write = 1'b0;
        alu_src   = 1'b0;
        reg_write = 1'b0;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        alu_op    = '0;
        busy      = (state != FETCH);
        fault     = (state == TRAP);
        case (state)
            // The only input-dependent outputs: the fetch strobe follows instr_valid,
            // and is held off while reset is asserted.
            FETCH: begin
                ir_write = bus.instr_valid & rst;
                pc_write = bus.instr_valid & rst;
            end
            DECODE: reg2loc = is_stur | is_cbz;
            EXEC: begin
                alu_op   = alu_code;
                alu_src  = is_mem;
                branch   = is_cbz;
                uncond   = is_b;
                pc_write = is_cbz | is_b;
            end
            MEM: begin
                mem_read  = is_ldur;
                mem_write = is_stur;
            end
            WB: begin
                reg_write = 1'b1;
                mem_reg   = is_ldur;
            end
            default: ;
        endcase
    end

    assign bus.Reg2Loc      = reg2loc;
    assign bus.UncondBranch = uncond;
    assign bus.Branch       = branch;
    assign bus.MemRead      = mem_read;
    assign bus.MemReg       = mem_reg;
    assign bus.MemWrite     = mem_write;
    assign bus.ALUscr       = alu_src;
    assign bus.RegWrite     = reg_write;
    assign bus.ALUop        = alu_op;
    assign bus.PCWrite      = pc_write;
    assign bus.IRWrite      = ir_write;
    assign bus.busy         = busy;
    assign bus.fault        = fault;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control vectors for each
// instruction class, memory waits, timeout, illegal opcode and async reset.
module tb_multicycle_control;
    localparam int IW = 32;
    localparam int AW = 4;

    // ctl bit order: Reg2Loc UncondBranch Branch MemRead MemReg MemWrite
    //                ALUscr RegWrite PCWrite IRWrite busy fault
    localparam logic [11:0] C_IDLE  = 12'h000;
    localparam logic [11:0] C_FETCH = 12'h00C;
    localparam logic [11:0] C_DEC   = 12'h002;
    localparam logic [11:0] C_DECR2 = 12'h802;
    localparam logic [11:0] C_EXM   = 12'h022;
    localparam logic [11:0] C_EXR   = 12'h002;
    localparam logic [11:0] C_EXCBZ = 12'h20A;
    localparam logic [11:0] C_EXB   = 12'h40A;
    localparam logic [11:0] C_MRD   = 12'h102;
    localparam logic [11:0] C_MWR   = 12'h042;
    localparam logic [11:0] C_WBLD  = 12'h092;
    localparam logic [11:0] C_WBR   = 12'h012;
    localparam logic [11:0] C_TRAP  = 12'h003;

    localparam logic [31:0] I_STUR = 32'hF8018041;
    localparam logic [31:0] I_LDUR = 32'hF8400041;
    localparam logic [31:0] I_ADD  = 32'h8B020020;
    localparam logic [31:0] I_SUB  = 32'hCB020020;
    localparam logic [31:0] I_ORR  = 32'hAA020020;
    localparam logic [31:0] I_AND  = 32'h8A020020;
    localparam logic [31:0] I_CBZ  = 32'hB4000040;
    localparam logic [31:0] I_B    = 32'h14000010;
    localparam logic [31:0] I_ILL  = 32'hFFE00000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_if #(.INSTR_W(IW), .ALUOP_W(AW)) bus();

    multicycle_control #(.INSTR_W(IW), .ALUOP_W(AW), .MAX_WAIT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ctl();
        return {bus.Reg2Loc, bus.UncondBranch, bus.Branch, bus.MemRead, bus.MemReg,
                bus.MemWrite, bus.ALUscr, bus.RegWrite, bus.PCWrite, bus.IRWrite,
                bus.busy, bus.fault};
    endfunction

    // One cycle: drive this cycle's inputs after the edge, then check outputs.
    task automatic cyc(input logic vld, input logic [31:0] ins, input logic rdy,
                       input string tag, input logic [11:0] ec, input logic [3:0] eop);
        @(posedge clk);
        #2;
        bus.instr_valid = vld;
        bus.instruction = ins;
        bus.mem_ready   = rdy;
        #1;
        chk({tag, "_ctl"}, 32'(ctl()), 32'(ec));
        chk({tag, "_op"},  32'(bus.ALUop), 32'(eop));
    endtask

    task automatic idle(input string tag);
        cyc(1'b0, 32'h0, 1'b0, tag, C_IDLE, 4'h0);
    endtask

    task automatic r_type(input logic [31:0] ins, input logic [3:0] op, input string tag);
        cyc(1'b1, ins, 1'b0, {tag, "_f"}, C_FETCH, 4'h0);
        cyc(1'b0, 32'h0, 1'b0, {tag, "_d"}, C_DEC, 4'h0);
        cyc(1'b0, 32'h0, 1'b0, {tag, "_e"}, C_EXR, op);
        cyc(1'b0, 32'h0, 1'b0, {tag, "_w"}, C_WBR, 4'h0);
    endtask

    task async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        chk(tag, 32'(ctl()), 32'(C_IDLE));
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.mem_ready   = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.instr_valid = 1'b1;
        bus.instruction = I_STUR;
        bus.mem_ready   = 1'b1;
        #3;
        chk("rst_t0", 32'(ctl()), 32'(C_IDLE));
        chk("rst_t0_op", 32'(bus.ALUop), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_held", 32'(ctl()), 32'(C_IDLE));
        #1;
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.mem_ready   = 1'b0;
        for (int i = 0; i < 10; i++) idle($sformatf("idle%0d", i));

        // STUR with three wait cycles; stray handshakes outside their states are ignored
        cyc(1'b1, I_STUR, 1'b1, "st_f", C_FETCH, 4'h0);
        cyc(1'b1, I_ADD,  1'b1, "st_d", C_DECR2, 4'h0);
        cyc(1'b0, 32'h0,  1'b1, "st_e", C_EXM, 4'h2);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, $sformatf("st_m%0d", i), C_MWR, 4'h0);
        cyc(1'b0, 32'h0, 1'b1, "st_m3", C_MWR, 4'h0);
        idle("st_done");

        // LDUR then ADD back-to-back
        cyc(1'b1, I_LDUR, 1'b0, "ld_f", C_FETCH, 4'h0);
        cyc(1'b0, 32'h0,  1'b0, "ld_d", C_DEC, 4'h0);
        cyc(1'b0, 32'h0,  1'b0, "ld_e", C_EXM, 4'h2);
        cyc(1'b0, 32'h0,  1'b1, "ld_m", C_MRD, 4'h0);
        cyc(1'b0, 32'h0,  1'b0, "ld_w", C_WBLD, 4'h0);
        r_type(I_ADD, 4'h2, "add");
        idle("add_done");

        r_type(I_SUB, 4'h6, "sub");
        r_type(I_ORR, 4'h1, "orr");
        r_type(I_AND, 4'h0, "and");
        idle("rt_done");

        // Branches
        cyc(1'b1, I_CBZ, 1'b0, "cbz_f", C_FETCH, 4'h0);
        cyc(1'b0, 32'h0, 1'b0, "cbz_d", C_DECR2, 4'h0);
        cyc(1'b0, 32'h0, 1'b0, "cbz_e", C_EXCBZ, 4'h7);
        cyc(1'b1, I_B,   1'b0, "b_f",   C_FETCH, 4'h0);
        cyc(1'b0, 32'h0, 1'b0, "b_d",   C_DEC, 4'h0);
        cyc(1'b0, 32'h0, 1'b0, "b_e",   C_EXB, 4'h0);
        idle("br_done");

        // LDUR: ready arrives exactly as the counter saturates -> completes
        cyc(1'b1, I_LDUR, 1'b0, "lw_f", C_FETCH, 4'h0);
        cyc(1'b0, 32'h0,  1'b0, "lw_d", C_DEC, 4'h0);
        cyc(1'b0, 32'h0,  1'b0, "lw_e", C_EXM, 4'h2);
        for (int i = 0; i < 15; i++) cyc(1'b0, 32'h0, 1'b0, $sformatf("lw_m%0d", i), C_MRD, 4'h0);
        cyc(1'b0, 32'h0, 1'b1, "lw_last", C_MRD, 4'h0);
        cyc(1'b0, 32'h0, 1'b0, "lw_w", C_WBLD, 4'h0);
        idle("lw_done");

        // LDUR with mem_ready stuck low -> TRAP, sticky, cleared by async reset
        cyc(1'b1, I_LDUR, 1'b0, "lt_f", C_FETCH, 4'h0);
        cyc(1'b0, 32'h0,  1'b0, "lt_d", C_DEC, 4'h0);
        cyc(1'b0, 32'h0,  1'b0, "lt_e", C_EXM, 4'h2);
        for (int i = 0; i < 16; i++) cyc(1'b0, 32'h0, 1'b0, $sformatf("lt_m%0d", i), C_MRD, 4'h0);
        for (int i = 0; i < 3; i++) cyc(1'b1, I_ADD, 1'b1, $sformatf("lt_trap%0d", i), C_TRAP, 4'h0);
        async_reset("lt_rst");
        idle("lt_post");

        // Illegal opcode
        cyc(1'b1, I_ILL, 1'b0, "il_f", C_FETCH, 4'h0);
        cyc(1'b0, 32'h0, 1'b0, "il_d", C_DEC, 4'h0);
        for (int i = 0; i < 3; i++) cyc(1'b1, I_ADD, 1'b0, $sformatf("il_trap%0d", i), C_TRAP, 4'h0);
        async_reset("il_rst");
        idle("il_post");

        // Reset in the middle of a STUR wait: no write completes afterwards
        cyc(1'b1, I_STUR, 1'b0, "sr_f", C_FETCH, 4'h0);
        cyc(1'b0, 32'h0,  1'b0, "sr_d", C_DECR2, 4'h0);
        cyc(1'b0, 32'h0,  1'b0, "sr_e", C_EXM, 4'h2);
        cyc(1'b0, 32'h0,  1'b0, "sr_m0", C_MWR, 4'h0);
        async_reset("sr_rst");
        cyc(1'b0, 32'h0, 1'b1, "sr_post0", C_IDLE, 4'h0);
        cyc(1'b0, 32'h0, 1'b1, "sr_post1", C_IDLE, 4'h0);
        r_type(I_ADD, 4'h2, "sr_add");
        idle("sr_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
